// File: rtl/adc045_acq_ctrl.sv
// Acquisition controller for the adc045 core: configures the core, paces sync
// pulses, averages 2^N samples per channel and streams results out.
module adc045_acq_ctrl #(
    parameter int unsigned SYNC_PERIOD = 50000,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned ACC_W       = 28
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        enable,
    input  logic [1:0]  cfg_channel,
    input  logic [2:0]  cfg_gain,
    input  logic [1:0]  cfg_dr,
    input  logic [2:0]  cfg_avg_log2,
    input  logic        adc_busy,
    input  logic        adc_rd_en,
    input  logic [23:0] adc_data,
    input  logic        adc_channel,
    output logic        adc_sync,
    output logic [13:0] adc_wreg_command,
    output logic [1:0]  adc_channel_choice,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        res_channel,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int unsigned DATA_W = 24;
    localparam int unsigned PER_W  = $clog2(SYNC_PERIOD + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXT_W  = ACC_W - DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        SYNC,
        WAIT,
        HOLD
    } state_t;

    state_t                   state;
    logic [1:0]               chan_sel;
    logic [2:0]               avg_n;
    logic [PER_W-1:0]         per_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [1:0]               exp_cnt;
    logic                     busy_low;
    logic signed [ACC_W-1:0]  acc [2];
    logic [CNT_W-1:0]         cnt [2];

    logic [1:0]               cfg_chan_m;
    logic [2:0]               cfg_avg_m;
    logic                     sample_ok;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         cnt_next;
    logic                     blk_done;
    logic [DATA_W-1:0]        blk_res;
    logic                     can_load;

    // Configuration mapping and the sample/accumulate datapath for the incoming rd_en
    always_comb begin
        cfg_chan_m = (cfg_channel == 2'b00) ? 2'b01 : cfg_channel;
        cfg_avg_m  = (cfg_avg_log2 > 3'd4) ? 3'd4 : cfg_avg_log2;
        sample_ok  = (state == WAIT) && adc_rd_en && chan_sel[adc_channel];
        acc_sum    = acc[adc_channel] + {{EXT_W{adc_data[DATA_W-1]}}, adc_data};
        cnt_next   = cnt[adc_channel] + CNT_W'(1);
        blk_done   = sample_ok && (cnt_next == (CNT_W'(1) << avg_n));
        blk_res    = DATA_W'(acc_sum >>> avg_n);
        can_load   = !res_valid || res_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state              <= IDLE;
            chan_sel           <= 2'b01;
            avg_n              <= 3'd0;
            per_cnt            <= '0;
            to_cnt             <= '0;
            exp_cnt            <= 2'd0;
            busy_low           <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            adc_sync           <= 1'b0;
            adc_wreg_command   <= {1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
            adc_channel_choice <= 2'b01;
            res_valid          <= 1'b0;
            res_data           <= '0;
            res_channel        <= 1'b0;
            timeout_err        <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            adc_sync <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (!enable && (state != IDLE)) begin
                // Run request withdrawn: abandon everything but the sticky flags
                state     <= IDLE;
                res_valid <= 1'b0;
                for (int i = 0; i < 2; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            chan_sel           <= cfg_chan_m;
                            avg_n              <= cfg_avg_m;
                            adc_channel_choice <= cfg_chan_m;
                            adc_wreg_command   <= {1'b0, cfg_gain, 1'b0, (cfg_chan_m == 2'b11),
                                                   cfg_dr, 2'b00, 1'b0, 1'b0, 2'b00};
                            timeout_err        <= 1'b0;
                            overrun            <= 1'b0;
                            busy_low           <= 1'b0;
                            for (int i = 0; i < 2; i++) begin
                                acc[i] <= '0;
                                cnt[i] <= '0;
                            end
                            state <= CONFIG;
                        end
                    end

                    CONFIG: begin
                        if (adc_busy) begin
                            busy_low <= 1'b0;
                        end else if (busy_low) begin
                            busy_low <= 1'b0;
                            adc_sync <= 1'b1;
                            state    <= SYNC;
                        end else begin
                            busy_low <= 1'b1;
                        end
                    end

                    SYNC: begin
                        to_cnt  <= TO_W'(TIMEOUT - 1);
                        per_cnt <= PER_W'(SYNC_PERIOD - 1);
                        exp_cnt <= (chan_sel == 2'b11) ? 2'd2 : 2'd1;
                        state   <= WAIT;
                    end

                    WAIT: begin
                        if (per_cnt != '0) begin
                            per_cnt <= per_cnt - PER_W'(1);
                        end
                        if (to_cnt != '0) begin
                            to_cnt <= to_cnt - TO_W'(1);
                        end
                        if (sample_ok) begin
                            exp_cnt <= exp_cnt - 2'd1;
                            if (blk_done) begin
                                acc[adc_channel] <= '0;
                                cnt[adc_channel] <= '0;
                                if (can_load) begin
                                    res_data    <= blk_res;
                                    res_channel <= adc_channel;
                                    res_valid   <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                acc[adc_channel] <= acc_sum;
                                cnt[adc_channel] <= cnt_next;
                            end
                        end
                        if (sample_ok && (exp_cnt == 2'd1)) begin
                            state <= HOLD;
                        end else if (to_cnt == '0) begin
                            // Core went quiet: drop partial blocks and reconfigure
                            timeout_err <= 1'b1;
                            busy_low    <= 1'b0;
                            for (int i = 0; i < 2; i++) begin
                                acc[i] <= '0;
                                cnt[i] <= '0;
                            end
                            state <= CONFIG;
                        end
                    end

                    HOLD: begin
                        // Leaving at count 1 keeps sync pulses exactly SYNC_PERIOD apart
                        if (per_cnt <= PER_W'(1)) begin
                            adc_sync <= 1'b1;
                            state    <= SYNC;
                        end else begin
                            per_cnt <= per_cnt - PER_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc045_acq_ctrl.sv
// Directed bench for adc045_acq_ctrl with hand-computed expectations.
module tb_adc045_acq_ctrl;

    localparam int unsigned SYNC_PERIOD = 16;
    localparam int unsigned TIMEOUT     = 40;

    logic        clk;
    logic        rst_l;
    logic        enable;
    logic [1:0]  cfg_channel;
    logic [2:0]  cfg_gain;
    logic [1:0]  cfg_dr;
    logic [2:0]  cfg_avg_log2;
    logic        adc_busy;
    logic        adc_rd_en;
    logic [23:0] adc_data;
    logic        adc_channel;
    logic        adc_sync;
    logic [13:0] adc_wreg_command;
    logic [1:0]  adc_channel_choice;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_data;
    logic        res_channel;
    logic        timeout_err;
    logic        overrun;

    int checks;
    int errors;
    int cyc;

    adc045_acq_ctrl #(
        .SYNC_PERIOD(SYNC_PERIOD),
        .TIMEOUT    (TIMEOUT),
        .ACC_W      (28)
    ) dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .enable            (enable),
        .cfg_channel       (cfg_channel),
        .cfg_gain          (cfg_gain),
        .cfg_dr            (cfg_dr),
        .cfg_avg_log2      (cfg_avg_log2),
        .adc_busy          (adc_busy),
        .adc_rd_en         (adc_rd_en),
        .adc_data          (adc_data),
        .adc_channel       (adc_channel),
        .adc_sync          (adc_sync),
        .adc_wreg_command  (adc_wreg_command),
        .adc_channel_choice(adc_channel_choice),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_channel       (res_channel),
        .timeout_err       (timeout_err),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse(input logic ch, input logic [23:0] d);
        adc_rd_en   = 1'b1;
        adc_channel = ch;
        adc_data    = d;
        tick();
        adc_rd_en   = 1'b0;
    endtask

    task automatic wait_sync();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (adc_sync) found = 1'b1;
        end
        chk("sync_seen", 32'(found), 32'd1);
    endtask

    // Sample taken on the WAIT cycle that follows a sync pulse
    task automatic sample(input logic ch, input logic [23:0] d);
        wait_sync();
        tick();
        pulse(ch, d);
    endtask

    task automatic restart(input logic [1:0] ch, input logic [2:0] g, input logic [1:0] dr,
                           input logic [2:0] avg);
        enable = 1'b0;
        tick();
        cfg_channel  = ch;
        cfg_gain     = g;
        cfg_dr       = dr;
        cfg_avg_log2 = avg;
        enable       = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sync_at;
        int n;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst_l        = 1'b0;
        enable       = 1'b0;
        cfg_channel  = 2'b00;
        cfg_gain     = 3'd0;
        cfg_dr       = 2'd0;
        cfg_avg_log2 = 3'd0;
        adc_busy     = 1'b0;
        adc_rd_en    = 1'b0;
        adc_data     = '0;
        adc_channel  = 1'b0;
        res_ready    = 1'b0;
        tick();
        tick();

        chk("rst_sync",    32'(adc_sync), 32'd0);
        chk("rst_wreg",    32'(adc_wreg_command), 32'd0);
        chk("rst_choice",  32'(adc_channel_choice), 32'd1);
        chk("rst_valid",   32'(res_valid), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_l = 1'b1;
        tick();

        // Both channels, gain 100, dr 01, no averaging
        cfg_channel  = 2'b11;
        cfg_gain     = 3'b100;
        cfg_dr       = 2'b01;
        cfg_avg_log2 = 3'd0;
        enable       = 1'b1;
        tick();
        chk("wreg_both",   32'(adc_wreg_command), 32'(14'b01000101000000));
        chk("choice_both", 32'(adc_channel_choice), 32'd3);
        chk("sync_early0", 32'(adc_sync), 32'd0);
        tick();
        chk("sync_early1", 32'(adc_sync), 32'd0);
        tick();
        chk("sync_first",  32'(adc_sync), 32'd1);
        sync_at = cyc;
        tick();
        chk("sync_1cyc",   32'(adc_sync), 32'd0);
        pulse(1'b0, 24'd5);
        chk("p0_valid", 32'(res_valid), 32'd1);
        chk("p0_data",  32'(res_data), 32'd5);
        chk("p0_chan",  32'(res_channel), 32'd0);
        res_ready = 1'b1;
        tick();
        chk("p0_accept", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        pulse(1'b1, 24'hFFFFFF);
        chk("ch2_valid", 32'(res_valid), 32'd1);
        chk("ch2_data",  32'(res_data), 32'hFFFFFF);
        chk("ch2_chan",  32'(res_channel), 32'd1);
        wait_sync();
        chk("sync_period", 32'(cyc - sync_at), 32'(SYNC_PERIOD));
        chk("held_valid",  32'(res_valid), 32'd1);
        enable = 1'b0;
        tick();
        chk("dis_valid", 32'(res_valid), 32'd0);
        res_ready = 1'b1;

        // Single ch1, average of 4: (8+8-4+0)>>>2 = 3; late HOLD sample ignored
        restart(2'b01, 3'b100, 2'b01, 3'd2);
        sample(1'b0, 24'd8);
        chk("wreg_ch1", 32'(adc_wreg_command), 32'(14'b01000001000000));
        pulse(1'b0, 24'd1000);
        sample(1'b0, 24'd8);
        sample(1'b0, 24'hFFFFFC);
        chk("avg_early", 32'(res_valid), 32'd0);
        sample(1'b0, 24'd0);
        chk("avg_valid", 32'(res_valid), 32'd1);
        chk("avg_data",  32'(res_data), 32'd3);
        chk("avg_chan",  32'(res_channel), 32'd0);

        // Channel 00 maps to ch1, avg 7 clamps to 16 samples of -32
        restart(2'b00, 3'b011, 2'b10, 3'd7);
        tick();
        chk("choice_00", 32'(adc_channel_choice), 32'd1);
        chk("wreg_00",   32'(adc_wreg_command), 32'(14'b00110010000000));
        for (int i = 0; i < 15; i++) sample(1'b0, 24'hFFFFE0);
        chk("clamp_early", 32'(res_valid), 32'd0);
        sample(1'b0, 24'hFFFFE0);
        chk("clamp_valid", 32'(res_valid), 32'd1);
        chk("clamp_data",  32'(res_data), 32'hFFFFE0);

        // Single ch2: a ch1 sample is discarded
        restart(2'b10, 3'b001, 2'b00, 3'd0);
        wait_sync();
        tick();
        pulse(1'b0, 24'h000010);
        tick();
        chk("ch1_dropped", 32'(res_valid), 32'd0);
        pulse(1'b1, 24'h000123);
        chk("ch2s_valid", 32'(res_valid), 32'd1);
        chk("ch2s_data",  32'(res_data), 32'h000123);
        chk("ch2s_chan",  32'(res_channel), 32'd1);

        // Overrun: consumer stalls across two completions
        res_ready = 1'b0;
        restart(2'b11, 3'b000, 2'b00, 3'd0);
        wait_sync();
        tick();
        pulse(1'b0, 24'h000111);
        pulse(1'b1, 24'h000222);
        chk("ovr_valid", 32'(res_valid), 32'd1);
        chk("ovr_data",  32'(res_data), 32'h000111);
        chk("ovr_chan",  32'(res_channel), 32'd0);
        chk("ovr_flag",  32'(overrun), 32'd1);
        res_ready = 1'b1;
        tick();
        chk("ovr_accept", 32'(res_valid), 32'd0);
        tick();
        chk("ovr_nosecond", 32'(res_valid), 32'd0);

        // Timeout: no rd_en after a sync
        wait_sync();
        n = 0;
        for (int i = 0; i < 100 && !timeout_err; i++) begin
            tick();
            n++;
        end
        chk("to_cycles",   32'(n), 32'(TIMEOUT + 1));
        chk("to_flag",     32'(timeout_err), 32'd1);
        chk("ovr_sticky",  32'(overrun), 32'd1);
        adc_busy = 1'b1;
        tick();
        tick();
        tick();
        chk("to_busy_nosync", 32'(adc_sync), 32'd0);
        adc_busy = 1'b0;
        tick();
        chk("to_resync0", 32'(adc_sync), 32'd0);
        tick();
        chk("to_resync1", 32'(adc_sync), 32'd1);

        // Reset mid-WAIT with a partial ch1 block pending
        restart(2'b11, 3'b000, 2'b00, 3'd1);
        tick();
        chk("en_clr_to",  32'(timeout_err), 32'd0);
        chk("en_clr_ovr", 32'(overrun), 32'd0);
        wait_sync();
        tick();
        pulse(1'b0, 24'd100);
        rst_l = 1'b0;
        tick();
        chk("mid_rst_wreg",   32'(adc_wreg_command), 32'd0);
        chk("mid_rst_choice", 32'(adc_channel_choice), 32'd1);
        chk("mid_rst_valid",  32'(res_valid), 32'd0);
        chk("mid_rst_sync",   32'(adc_sync), 32'd0);
        rst_l = 1'b1;
        sample(1'b0, 24'd6);
        pulse(1'b1, 24'd0);
        sample(1'b0, 24'd10);
        chk("post_rst_valid", 32'(res_valid), 32'd1);
        chk("post_rst_data",  32'(res_data), 32'd8);
        chk("post_rst_chan",  32'(res_channel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc045_acq_ctrl.md
Name: adc045_acq_ctrl

Overview:
- Acquisition controller in front of the adc045 core.
- Latches a host configuration and drives the core's wreg_command and channel_choice.
- Schedules periodic sync pulses, collects rd_en/data per channel, and averages 2^N samples per channel.
- Presents averaged results on a valid/ready stream, with timeout recovery and overrun flagging.

Parameters:
- SYNC_PERIOD, 50000: clk cycles between sync pulses; must be at least 4.
- TIMEOUT, 100000: clk cycles allowed from a sync pulse to the last expected rd_en.
- ACC_W, 28: accumulator width; 24 + max averaging log2 (4).

Ports:
- clk  in  1  system clock
- rst_l  in  1  synchronous active-low reset
- enable  in  1  run request; level-sensitive
- cfg_channel  in  2  01 = ch1, 10 = ch2, 11 = both; 00 is treated as 01
- cfg_gain  in  3  GAIN field
- cfg_dr  in  2  DR field
- cfg_avg_log2  in  3  averaging exponent; values above 4 clamp to 4
- adc_busy  in  1  core busy
- adc_rd_en  in  1  one-cycle strobe: adc_data/adc_channel valid
- adc_data  in  24  signed two's-complement sample
- adc_channel  in  1  0 = ch1, 1 = ch2
- adc_sync  out  1  one-cycle sync pulse to core
- adc_wreg_command  out  14  core register word
- adc_channel_choice  out  2  core channel select
- res_valid  out  1  result available
- res_ready  in  1  consumer accept
- res_data  out  24  averaged signed sample
- res_channel  out  1  channel of res_data
- timeout_err  out  1  sticky: a timeout occurred
- overrun  out  1  sticky: a result was dropped

Behaviour:
- Reset (rst_l=0 at a clk edge):
  - State returns to IDLE.
  - All outputs are 0, except adc_channel_choice=2'b01 and adc_wreg_command={1'b0,3'b000,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00}.
  - Counters and accumulators are cleared.
- Config word: adc_wreg_command = {POL=0, GAIN, REF=0, MODE, DR, 2'b00, SCALE=0, BUF_DIS=0, 2'b00}. MODE=1 iff the latched channel is 11.
- IDLE:
  - On enable=1: latch cfg_* (after the 00→01 and >4→4 mappings) and drive the new command/choice.
  - Clear timeout_err and overrun, clear accumulators, go to CONFIG.
- CONFIG: wait until adc_busy=0 for 2 consecutive cycles, then go to SYNC.
- SYNC:
  - adc_sync=1 for exactly this cycle.
  - Load the timeout counter and the expected count E (E=2 if MODE, else 1).
  - Load the period counter with SYNC_PERIOD-1, then go to WAIT.
- WAIT: the period counter decrements every cycle in WAIT and HOLD.
  - Each adc_rd_en whose channel is selected goes to ACCUM and decrements E. An unselected channel is discarded.
  - E reaching 0 → HOLD.
  - Timeout counter reaching 0 with E>0 → set timeout_err, clear accumulators, go to CONFIG.
- HOLD: when the period counter reaches 0, go to SYNC. A late rd_en in HOLD is discarded.
- Accumulation:
  - Each channel has its own ACC_W-bit accumulator and 5-bit count. The sample is sign-extended and added.
  - When the count reaches 2^n, the result is acc >>> n, truncated to 24 bits. Accumulator and count reset in the same cycle.
  - The result loads res_data/res_channel and sets res_valid on the next cycle, so latency is 1 clk from the rd_en that completes the block.
  - With n=0, every sample passes through unchanged with 1-cycle latency.
- Handshake:
  - res_valid stays high until res_valid & res_ready. res_data is stable while it is high.
  - If a new result completes while res_valid=1 and res_ready=0: the new result is dropped and overrun is set.
  - If res_ready=1 in that same cycle: the old result is accepted and the new one loads (no overrun).
- enable=0 in any non-IDLE state: go to IDLE next cycle. res_valid and accumulators clear; the sticky flags hold.
- Only one rd_en can arrive per cycle, so at most one channel completes per cycle.

Test Plan:
- Reset, then enable with cfg_channel=11, gain=100, dr=01, avg=0, adc_busy=0: wreg_command=14'b0100_0101_0000_00 (MODE=1). adc_sync pulses at cycle 3 after enable, then every SYNC_PERIOD.
- Single ch1, avg_log2=2, samples +8, +8, -4, 0: res_data=3 (12>>>2), res_channel=0, res_valid one cycle after the 4th rd_en.
- Both channels, avg=0, rd_en on ch2 with 0xFFFFFF: res_data=0xFFFFFF, res_channel=1. A ch1 sample of 0x000010 in single-ch2 mode produces no output.
- res_ready held 0 while two results complete: the first is kept, overrun=1. Then res_ready=1: the first is accepted and no second result appears.
- No rd_en after sync for TIMEOUT cycles: timeout_err=1 and the block returns to CONFIG. After busy is low for 2 cycles a new sync pulse appears.
- rst_l=0 mid-WAIT with a partial accumulation: all outputs reset. The next run's first result excludes the old samples.
